regfile_write_arbiter: RTL and testbench

//  Shares the register file's single write port (Reg_Write/Reg_write_ad/Reg_write_data) among
//  NUM_REQ writeback requesters (e.g. ALU, load unit, debug/inr path).

---
 rtl/regfile_write_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter that shares the register file's single
// write port among NUM_REQ writeback requesters using a valid/ready handshake.
// The write strobe, address, data and grant index are registered, so a transfer
// reaches the regfile one cycle after it is accepted.
// Optional build macro REGFILE_ARB_LOCK_EN adds Req_lock and a LOCKED state in which
// only the owning requester can be granted.
module regfile_write_arbiter #(
    parameter int unsigned N       = 16,
    parameter int unsigned M       = 3,
    parameter int unsigned NUM_REQ = 3,
    localparam int unsigned IDW    = $clog2(NUM_REQ)
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic [NUM_REQ-1:0]   Req_valid,
`ifdef REGFILE_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]   Req_lock,
`endif
    input  logic [NUM_REQ*M-1:0] Req_addr,
    input  logic [NUM_REQ*N-1:0] Req_data,
    output logic [NUM_REQ-1:0]   Req_ready,
    output logic                 Reg_Write,
    output logic [M-1:0]         Reg_write_ad,
    output logic [N-1:0]         Reg_write_data,
    output logic [IDW-1:0]       Grant_id,
    input  logic                 Clear_cnt,
    output logic [7:0]           Collision_cnt
);

    localparam int unsigned    PW   = IDW + 1;
    localparam logic [IDW-1:0] LAST = IDW'(NUM_REQ - 1);

`ifdef REGFILE_ARB_LOCK_EN
    typedef enum logic [1:0] {IDLE, ACTIVE, LOCKED} state_t;
`else
    typedef enum logic {IDLE, ACTIVE} state_t;
`endif

    state_t             state_q, state_d;
    logic [IDW-1:0]     rr_ptr, rr_ptr_d;
    logic [NUM_REQ-1:0] eligible;
    logic               found;
    logic [IDW-1:0]     winner;
    logic [IDW-1:0]     next_ptr;
    logic               transfer;
    logic [PW-1:0]      sum;
    logic [IDW-1:0]     idx;
    logic [M-1:0]       win_addr;
    logic [N-1:0]       win_data;
    logic [3:0]         nvalid;
    logic               contention;
`ifdef REGFILE_ARB_LOCK_EN
    logic [IDW-1:0]     owner_q, owner_d;
`endif

    // Requesters allowed to win this cycle (only the owner while locked)
    always_comb begin
        eligible = Req_valid;
`ifdef REGFILE_ARB_LOCK_EN
        if (state_q == LOCKED) begin
            eligible = Req_valid & (NUM_REQ'(1) << owner_q);
        end
`endif
    end

    // First eligible requester searching upward from rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        idx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr} + PW'(i);
            idx = (sum >= PW'(NUM_REQ)) ? IDW'(sum - PW'(NUM_REQ)) : IDW'(sum);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign transfer = Reset & Enable & found;
    assign next_ptr = (winner == LAST) ? '0 : winner + 1'b1;

    // One-hot grant; zero while disabled or in reset
    always_comb begin
        Req_ready = '0;
        if (transfer) begin
            Req_ready[winner] = 1'b1;
        end
    end

    // Select the winner's address and data from the packed request buses
    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner == IDW'(i)) begin
                win_addr = Req_addr[i*M +: M];
                win_data = Req_data[i*N +: N];
            end
        end
    end

    // Contention: two or more requesters valid while arbitration is on
    always_comb begin
        nvalid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            nvalid = nvalid + 4'(Req_valid[i]);
        end
        contention = Enable && (nvalid >= 4'd2);
    end

    // Next-state, pointer and lock-owner update; everything holds while disabled
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr;
`ifdef REGFILE_ARB_LOCK_EN
        owner_d  = owner_q;
`endif
        if (Enable) begin
            if (transfer) begin
                state_d  = ACTIVE;
                rr_ptr_d = next_ptr;
`ifdef REGFILE_ARB_LOCK_EN
                if (Req_lock[winner]) begin
                    state_d  = LOCKED;
                    owner_d  = winner;
                    rr_ptr_d = rr_ptr;
                end
`endif
            end else begin
`ifdef REGFILE_ARB_LOCK_EN
                if (state_q != LOCKED) begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
        end
    end

    // FSM state, round-robin pointer and lock owner
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            rr_ptr  <= '0;
`ifdef REGFILE_ARB_LOCK_EN
            owner_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            rr_ptr  <= rr_ptr_d;
`ifdef REGFILE_ARB_LOCK_EN
            owner_q <= owner_d;
`endif
        end
    end

    // Registered regfile write port and saturating contention counter
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Reg_Write      <= 1'b0;
            Reg_write_ad   <= '0;
            Reg_write_data <= '0;
            Grant_id       <= '0;
            Collision_cnt  <= '0;
        end else begin
            Reg_Write <= transfer;
            if (transfer) begin
                Reg_write_ad   <= win_addr;
                Reg_write_data <= win_data;
                Grant_id       <= winner;
            end
            if (Clear_cnt) begin
                Collision_cnt <= '0;
            end else if (contention && (Collision_cnt != 8'hFF)) begin
                Collision_cnt <= Collision_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed scenarios plus randomized traffic checked against
// a behavioural model of the round-robin arbiter kept in this bench.
module tb_regfile_write_arbiter;

    localparam int unsigned N       = 16;
    localparam int unsigned M       = 3;
    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned IDW     = 2;

    logic                 Clock = 1'b0;
    logic                 Reset;
    logic                 Enable;
    logic                 Clear_cnt;
    logic [NUM_REQ-1:0]   Req_valid;
    logic [NUM_REQ*M-1:0] Req_addr;
    logic [NUM_REQ*N-1:0] Req_data;
    logic [NUM_REQ-1:0]   Req_ready;
    logic                 Reg_Write;
    logic [M-1:0]         Reg_write_ad;
    logic [N-1:0]         Reg_write_data;
    logic [IDW-1:0]       Grant_id;
    logic [7:0]           Collision_cnt;
`ifdef REGFILE_ARB_LOCK_EN
    logic [NUM_REQ-1:0]   Req_lock;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int           m_ptr;
    int           m_cnt;
    int           m_own;
    logic         m_we;
    logic [M-1:0] m_ad;
    logic [N-1:0] m_data;
    int           m_gid;
    int           last_w;

    regfile_write_arbiter #(.N(N), .M(M), .NUM_REQ(NUM_REQ)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Enable         (Enable),
        .Req_valid      (Req_valid),
`ifdef REGFILE_ARB_LOCK_EN
        .Req_lock       (Req_lock),
`endif
        .Req_addr       (Req_addr),
        .Req_data       (Req_data),
        .Req_ready      (Req_ready),
        .Reg_Write      (Reg_Write),
        .Reg_write_ad   (Reg_write_ad),
        .Reg_write_data (Reg_write_data),
        .Grant_id       (Grant_id),
        .Clear_cnt      (Clear_cnt),
        .Collision_cnt  (Collision_cnt)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Winner by the arbitration rule: first valid requester from the pointer, wrapping
    function automatic int pick();
        if (m_own >= 0) return Req_valid[m_own] ? m_own : -1;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            int j;
            j = (m_ptr + i) % int'(NUM_REQ);
            if (Req_valid[j]) return j;
        end
        return -1;
    endfunction

    // One clock cycle: drive inputs, check grant, clock, check registered outputs
    task automatic step(input logic [NUM_REQ-1:0] v, input logic en, input logic clr);
        int w;
        int pc;
        Req_valid = v;
        Enable    = en;
        Clear_cnt = clr;
        #1;
        w  = en ? pick() : -1;
        pc = $countones(v);
        chk("ready", 32'(Req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
        @(posedge Clock);
        #1;
        if (w >= 0) begin
            m_we   = 1'b1;
            m_ad   = Req_addr[w*M +: M];
            m_data = Req_data[w*N +: N];
            m_gid  = w;
`ifdef REGFILE_ARB_LOCK_EN
            if (Req_lock[w]) begin
                m_own = w;
            end else begin
                m_own = -1;
                m_ptr = (w + 1) % int'(NUM_REQ);
            end
`else
            m_ptr = (w + 1) % int'(NUM_REQ);
`endif
        end else begin
            m_we = 1'b0;
        end
        if (clr) m_cnt = 0;
        else if (en && pc >= 2 && m_cnt < 255) m_cnt = m_cnt + 1;
        last_w = w;
        chk("we",   32'(Reg_Write),      32'(m_we));
        chk("ad",   32'(Reg_write_ad),   32'(m_ad));
        chk("data", 32'(Reg_write_data), 32'(m_data));
        chk("gid",  32'(Grant_id),       32'(m_gid));
        chk("cnt",  32'(Collision_cnt),  32'(m_cnt));
        @(negedge Clock);
    endtask

    // Asynchronous reset pulse; outputs must clear immediately
    task automatic do_reset();
        Reset = 1'b0;
        #1;
        chk("rst_we",    32'(Reg_Write),      32'd0);
        chk("rst_ready", 32'(Req_ready),      32'd0);
        chk("rst_ad",    32'(Reg_write_ad),   32'd0);
        chk("rst_data",  32'(Reg_write_data), 32'd0);
        chk("rst_gid",   32'(Grant_id),       32'd0);
        chk("rst_cnt",   32'(Collision_cnt),  32'd0);
        m_ptr = 0; m_cnt = 0; m_own = -1; m_we = 1'b0;
        m_ad = '0; m_data = '0; m_gid = 0;
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
    endtask

    initial begin
        logic [NUM_REQ-1:0] v;
        Reset = 1'b1; Enable = 1'b0; Clear_cnt = 1'b0;
        Req_valid = '0; Req_addr = '0; Req_data = '0;
`ifdef REGFILE_ARB_LOCK_EN
        Req_lock = '0;
`endif
        @(negedge Clock);

        // Reset with all requesters valid, then first grant goes to req0
        Req_valid = 3'b111; Enable = 1'b1;
        Req_addr = {3'd6, 3'd4, 3'd2};
        Req_data = {16'h2222, 16'h1111, 16'h0000};
        do_reset();
        step(3'b111, 1'b1, 1'b0);
        chk("first_gid", 32'(Grant_id), 32'd0);

        // Sustained contention rotates 0,1,2,0,1,2 and counts six cycles
        for (int k = 1; k < 6; k++) begin
            step(3'b111, 1'b1, 1'b0);
            chk("rr_order", 32'(Grant_id), 32'(k % 3));
        end
        chk("cnt6", 32'(Collision_cnt), 32'd6);

        // Single requester
        Req_addr[1*M +: M] = 3'd5;
        Req_data[1*N +: N] = 16'hBEEF;
        step(3'b010, 1'b1, 1'b0);
        chk("single_ad",   32'(Reg_write_ad),   32'd5);
        chk("single_data", 32'(Reg_write_data), 32'hBEEF);
        chk("single_gid",  32'(Grant_id),       32'd1);

        // Reset while a write is in flight squashes it
        do_reset();

        // Same address from req0 and req2, with a disabled cycle in between
        Req_addr[0*M +: M] = 3'd3; Req_data[0*N +: N] = 16'd1;
        Req_addr[2*M +: M] = 3'd3; Req_data[2*N +: N] = 16'd2;
        step(3'b101, 1'b1, 1'b0);
        chk("same_first", 32'(Reg_write_data), 32'd1);
        step(3'b100, 1'b0, 1'b0);
        chk("dis_we", 32'(Reg_Write), 32'd0);
        step(3'b100, 1'b1, 1'b0);
        chk("same_second", 32'(Reg_write_data), 32'd2);
        chk("same_ad",     32'(Reg_write_ad),   32'd3);

        // Counter saturation, then clear overriding contention
        for (int k = 0; k < 300; k++) step(3'b111, 1'b1, 1'b0);
        chk("sat", 32'(Collision_cnt), 32'd255);
        step(3'b111, 1'b1, 1'b1);
        chk("clr", 32'(Collision_cnt), 32'd0);

`ifdef REGFILE_ARB_LOCK_EN
        // Lock: req1 keeps the port for three transfers, then 2 and 0 follow
        do_reset();
        step(3'b001, 1'b1, 1'b0);
        Req_lock = 3'b010;
        step(3'b111, 1'b1, 1'b0);
        chk("lock_a", 32'(Grant_id), 32'd1);
        step(3'b111, 1'b1, 1'b0);
        chk("lock_b", 32'(Grant_id), 32'd1);
        Req_lock = 3'b000;
        step(3'b111, 1'b1, 1'b0);
        chk("lock_c", 32'(Grant_id), 32'd1);
        step(3'b101, 1'b1, 1'b0);
        chk("unlock_a", 32'(Grant_id), 32'd2);
        step(3'b001, 1'b1, 1'b0);
        chk("unlock_b", 32'(Grant_id), 32'd0);
`endif

        // Random traffic: requests held until granted, then possibly replaced
        do_reset();
        v = '0;
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (!v[i] && $urandom_range(0, 1) == 1) begin
                    v[i] = 1'b1;
                    Req_addr[i*M +: M] = M'($urandom);
                    Req_data[i*N +: N] = N'($urandom);
                end
            end
            step(v, ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0));
            if (last_w >= 0) v[last_w] = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
